// File: rtl/seq_det.sv
// Moore detector for the serial pattern 1-0-1-0 with overlapping or restarting match mode.
// Optional match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
`ifdef SEQ_DET_COUNT_EN
  output logic [7:0] match_count,
`endif
  output logic       out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state_q, state_d;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S1 : S2;
      S2:      state_d = x ? S3 : S0;
      S3:      state_d = x ? S1 : S4;
      // The trailing "10" of a match seeds "101" only in overlap mode
      S4:      state_d = x ? (OVERLAP ? S3 : S1) : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  // Decoded straight from the state register, so there is no path from x
  assign out = (state_q == S4);

`ifdef SEQ_DET_COUNT_EN
  logic [7:0] match_count_q, match_count_d;

  always_comb begin
    match_count_d = match_count_q;
    if (state_d == S4) match_count_d = match_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) match_count_q <= 8'd0;
    else       match_count_q <= match_count_d;
  end

  assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_seq_det.sv
// Bench for seq_det: directed vector table, counter wrap sequence and a randomized
// run against a bit-history reference model, for both OVERLAP settings.
module tb_seq_det;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic out1, out0;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt1, cnt0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det #(.OVERLAP(1'b1)) u_ov (
    .clk(clk), .reset(reset), .x(x),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt1),
`endif
    .out(out1)
  );

  seq_det #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .reset(reset), .x(x),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt0),
`endif
    .out(out0)
  );

  // Reference model: bits seen since the last restart; a match is the last four being 1010.
  // Non-overlap mode forgets all history once a match completes.
  logic [3:0] hist1, hist0;
  int         n1, n0;
  bit         m1, m0;
  int         mc1, mc0;

  task automatic model_step(input bit b, input bit r);
    if (r) begin
      hist1 = 4'b0; n1 = 0; m1 = 1'b0; mc1 = 0;
      hist0 = 4'b0; n0 = 0; m0 = 1'b0; mc0 = 0;
    end else begin
      hist1 = {hist1[2:0], b}; n1++;
      hist0 = {hist0[2:0], b}; n0++;
      m1 = (n1 >= 4) && (hist1 == 4'b1010);
      m0 = (n0 >= 4) && (hist0 == 4'b1010);
      if (m1) mc1 = (mc1 + 1) % 256;
      if (m0) begin mc0 = (mc0 + 1) % 256; n0 = 0; hist0 = 4'b0; end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one bit (and reset level) for one rising edge, then sample 1 time unit later.
  task automatic step(input bit b, input bit r);
    x = b; reset = r;
    @(posedge clk);
    #1;
    model_step(b, r);
  endtask

  typedef struct {
    bit x;
    bit rst;
    bit exp_ov;
    bit exp_no;
  } vec_t;

  vec_t vecs[$];

  initial begin
    x = 1'b0; reset = 1'b1;
    hist1 = 4'b0; hist0 = 4'b0; n1 = 0; n0 = 0; m1 = 1'b0; m0 = 1'b0; mc1 = 0; mc0 = 0;
    @(negedge clk);

    vecs = '{
      // reset held for two edges with x toggling
      '{1, 1, 0, 0}, '{0, 1, 0, 0},
      // 1,0,1,0,1,0,0: two pulses with overlap, one without
      '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 1, 1},
      '{1, 0, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 0},
      // 1,1,0,1,1,0,1,0: S1 self-loop and S3 -> S1, single pulse at end
      '{1, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0},
      '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 1, 1},
      // leave S4, then 1,0,1 / reset / 0 must not match
      '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0},
      '{0, 1, 0, 0}, '{0, 0, 0, 0},
      // 1,0,1,0 after release: one pulse
      '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 1, 1},
      // reset while in S4 drops out on that same edge
      '{1, 1, 0, 0},
      // long runs of 0s and 1s never match
      '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{1, 0, 0, 0}, '{1, 0, 0, 0}
    };

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].x, vecs[i].rst);
      chk($sformatf("vec%0d_ov", i), int'(out1), int'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_no", i), int'(out0), int'(vecs[i].exp_no));
    end

`ifdef SEQ_DET_COUNT_EN
    // Counter: "10" then 130 x "10" gives 130 overlapping matches; extend to 257 -> wraps to 1
    step(0, 1);
    chk("cnt_reset", int'(cnt1), 0);
    step(1, 0); step(0, 0);
    for (int i = 0; i < 130; i++) begin step(1, 0); step(0, 0); end
    chk("cnt_130", int'(cnt1), 130);
    chk("cnt_130_no", int'(cnt0), mc0);
    for (int i = 0; i < 127; i++) begin step(1, 0); step(0, 0); end
    chk("cnt_wrap", int'(cnt1), 1);
    chk("cnt_wrap_no", int'(cnt0), mc0);
`endif

    // Randomized run against the model, occasional resets mid-pattern
    step(0, 1);
    for (int i = 0; i < 3000; i++) begin
      bit b, r;
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 59) == 0);
      step(b, r);
      chk("rnd_ov", int'(out1), int'(m1));
      chk("rnd_no", int'(out0), int'(m0));
`ifdef SEQ_DET_COUNT_EN
      chk("rnd_cnt_ov", int'(cnt1), mc1);
      chk("rnd_cnt_no", int'(cnt0), mc0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det.md
Name: seq_det

Overview:
- Serial bit-pattern detector: samples one input bit `x` per rising clock edge and flags every occurrence of the pattern 1-0-1-0.
- Moore FSM; the flag is a registered, single-cycle pulse.
- Used as a small control/monitor block on a serial data line in the same clock domain as its source.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the trailing "10" of a match seeds the next match); 0 = after a match, detection restarts from scratch.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- x  input  1  serial data bit, sampled on each rising clk edge
- out  output  1  detection flag; high for one cycle after 1010 completes

Behaviour:
- One clock; reset is synchronous and active-high.
  - Reset is sampled only on rising clk edges.
  - While reset is high at an edge: state <= S0, and x is ignored.
- Reset values: state S0, out 0.
- The state register is the only storage. `out` is decoded purely from state (Moore) and is glitch-free, with no combinational path from x to out.
- States:
  - S0: idle / nothing matched
  - S1: "1" seen
  - S2: "10" seen
  - S3: "101" seen
  - S4: "1010" seen (match)
- Transitions (x=0 / x=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S4 / S1
  - S4 with OVERLAP=1 -> S0 / S3
  - S4 with OVERLAP=0 -> S0 / S1
- out = 1 iff state == S4.
- Latency: out rises on the clk edge that samples the 4th bit (final 0) and falls on the next edge, unless the stream immediately completes another match.
  - With OVERLAP=1, the earliest re-assertion is 2 cycles after the previous match (input 101010 gives out pulses 2 cycles apart).
  - S4 never self-loops, so out is never high for 2 consecutive cycles.
- State encoding: 3-bit binary, S0=0..S4=4.
  - Unused codes 5..7 return to S0 on the next edge, with out=0 while in them.
- Reset mid-pattern: the partial match is discarded, and the bits after reset deasserts start from S0.
  - If reset is asserted while in S4, out drops on that same edge.
- Long runs:
  - A run of 1s holds the FSM in S1.
  - A run of 0s holds it in S0.
  - "10" followed by 0 returns to S0.
- x must be synchronous to clk and meet setup/hold; no internal synchronizer.

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- When defined:
  - Adds output port `match_count`, 8 bits.
  - It increments by 1 on every edge where the next state is S4.
  - It wraps 255 -> 0.
  - It clears to 0 on reset.
- When undefined: the port and counter do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset held high for 2 edges with x toggling -> state S0, out 0 throughout; then release.
- OVERLAP=1, x stream 1,0,1,0,1,0,0 (one bit per edge) -> out=1 in the cycle after the 4th bit and after the 6th bit; 0 in all other cycles (exactly 2 pulses).
- OVERLAP=0, same stream 1,0,1,0,1,0,0 -> exactly 1 pulse, after the 4th bit; bits 5-6 give no pulse.
- Stream 1,1,0,1,1,0,1,0 -> single pulse after the final 0 (checks S3 -> S1 on x=1 and S1 self-loop).
- Stream 1,0,1 then reset for one edge, then 0 -> no pulse; after release, 1,0,1,0 -> one pulse.
- SEQ_DET_COUNT_EN defined, OVERLAP=1, 130 repetitions of "10" after an initial "10" -> match_count equals 130 mod 256, and wraps correctly when the count is extended to 257 matches (-> 1).
